// File: rtl/zle_param.sv
// Zero run-length encoder: nonzero words pass as literal tokens, zero runs
// collapse into one run token; EOS flushes any partial run, bypass forces literals.
module zle_param #(
  parameter int DW     = 3,
  parameter int CW     = 4,
  parameter int MAXRUN = 15,
  localparam int OW    = ((DW > CW) ? DW : CW) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] i_d,
  input  logic          i_eos,
  input  logic          i_byp,
  input  logic          i_v,
  output logic          i_b,
  output logic [OW-1:0] o_d,
  output logic          o_eos,
  output logic          o_v,
  input  logic          o_b
);

  if (MAXRUN < 1 || MAXRUN > (2**CW) - 1) begin : g_bad_maxrun
    $error("zle_param: MAXRUN out of range 1..2^CW-1");
  end

  localparam logic [1:0] ACCEPT   = 2'd0;
  localparam logic [1:0] PEND_LIT = 2'd1;
  localparam logic [1:0] PEND_EOS = 2'd2;

  logic [1:0]    state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [DW-1:0] pend, nxt_pend;
  logic [CW:0]   cnt_inc;
  logic          can_load, in_xfer, load, ld_eos;
  logic [OW-1:0] ld_d;

  function automatic logic [OW-1:0] run_tok(input logic [CW-1:0] n);
    run_tok = '0;
    run_tok[OW-1] = 1'b1;
    run_tok[CW-1:0] = n;
  endfunction

  function automatic logic [OW-1:0] lit_tok(input logic [DW-1:0] d);
    lit_tok = '0;
    lit_tok[DW-1:0] = d;
  endfunction

  assign can_load = !o_v || !o_b;
  assign i_b      = reset || (state != ACCEPT) || !can_load;
  assign in_xfer  = i_v && !i_b;
  assign cnt_inc  = {1'b0, cnt} + 1'b1;

  always_comb begin
    load      = 1'b0;
    ld_d      = '0;
    ld_eos    = 1'b0;
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_pend  = pend;
    case (state)
      ACCEPT: if (in_xfer) begin
        if (i_eos) begin
          load = 1'b1;
          if (cnt != '0) begin
            // flush the partial run first; EOS follows from PEND_EOS
            ld_d      = run_tok(cnt);
            nxt_cnt   = '0;
            nxt_state = PEND_EOS;
          end else begin
            ld_eos = 1'b1;
          end
        end else if (i_d == '0 && !i_byp) begin
          if (cnt_inc == (CW+1)'(MAXRUN)) begin
            load    = 1'b1;
            ld_d    = run_tok(CW'(MAXRUN));
            nxt_cnt = '0;
          end else begin
            nxt_cnt = cnt_inc[CW-1:0];
          end
        end else if (cnt == '0) begin
          load = 1'b1;
          ld_d = lit_tok(i_d);
        end else begin
          load      = 1'b1;
          ld_d      = run_tok(cnt);
          nxt_cnt   = '0;
          nxt_pend  = i_d;
          nxt_state = PEND_LIT;
        end
      end
      PEND_LIT: if (can_load) begin
        load      = 1'b1;
        ld_d      = lit_tok(pend);
        nxt_state = ACCEPT;
      end
      PEND_EOS: if (can_load) begin
        load      = 1'b1;
        ld_eos    = 1'b1;
        nxt_state = ACCEPT;
      end
      default: begin
        nxt_state = ACCEPT;
        nxt_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ACCEPT;
      cnt   <= '0;
      pend  <= '0;
      o_v   <= 1'b0;
      o_d   <= '0;
      o_eos <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      pend  <= nxt_pend;
      if (load) begin
        o_v   <= 1'b1;
        o_d   <= ld_d;
        o_eos <= ld_eos;
      end else if (o_v && !o_b) begin
        o_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zle_param.sv
// Directed bench for zle_param: default-parameter vector table plus a
// hand-written sequence on a DW=8/CW=3/MAXRUN=5 instance.
module tb_zle_param;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] i_d;
  logic       i_eos, i_byp, i_v, o_b;
  logic       i_b;
  logic [4:0] o_d;
  logic       o_eos, o_v;

  logic [7:0] d2;
  logic       v2;
  logic       ib2, oeos2, ov2;
  logic [8:0] od2;

  int errs = 0;
  int checks = 0;

  always #5 clock = ~clock;

  zle_param dut (
    .clock(clock), .reset(reset), .i_d(i_d), .i_eos(i_eos), .i_byp(i_byp),
    .i_v(i_v), .i_b(i_b), .o_d(o_d), .o_eos(o_eos), .o_v(o_v), .o_b(o_b)
  );

  zle_param #(.DW(8), .CW(3), .MAXRUN(5)) dut2 (
    .clock(clock), .reset(reset), .i_d(d2), .i_eos(1'b0), .i_byp(1'b0),
    .i_v(v2), .i_b(ib2), .o_d(od2), .o_eos(oeos2), .o_v(ov2), .o_b(1'b0)
  );

  typedef struct {
    string      nm;
    logic       rst;
    logic [2:0] d;
    logic       eos, byp, v, ob;
    logic       ib;    // i_b expected during the cycle
    logic       ov;    // registered outputs expected after the edge
    logic [4:0] od;
    logic       oeos;
  } vec_t;

  vec_t vq[$];

  function automatic void add(string nm, logic rst, logic [2:0] d, logic eos, logic byp,
                              logic v, logic ob, logic ib, logic ov, logic [4:0] od, logic oeos);
    vec_t t;
    t.nm = nm; t.rst = rst; t.d = d; t.eos = eos; t.byp = byp; t.v = v; t.ob = ob;
    t.ib = ib; t.ov = ov; t.od = od; t.oeos = oeos;
    vq.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; i_d = '0; i_eos = 0; i_byp = 0; i_v = 0; o_b = 0;
    d2 = '0; v2 = 0;

    // reset state
    add("rst0", 1, 0, 0, 0, 0, 0, 1, 0, 5'h00, 0);
    add("rst1", 1, 0, 0, 0, 1, 0, 1, 0, 5'h00, 0);
    // 5,0,0,3 -> lit 5, run 2, lit 3; busy one cycle after 3
    add("lit5",  0, 5, 0, 0, 1, 0, 0, 1, 5'h05, 0);
    add("z1",    0, 0, 0, 0, 1, 0, 0, 0, 5'h00, 0);
    add("z2",    0, 0, 0, 0, 1, 0, 0, 0, 5'h00, 0);
    add("run2",  0, 3, 0, 0, 1, 0, 0, 1, 5'h12, 0);
    add("lit3",  0, 0, 0, 0, 0, 0, 1, 1, 5'h03, 0);
    add("idle1", 0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0);
    // 16 zeros then EOS
    for (int k = 1; k <= 14; k++)
      add("zrun", 0, 0, 0, 0, 1, 0, 0, 0, 5'h00, 0);
    add("run15", 0, 0, 0, 0, 1, 0, 0, 1, 5'h1F, 0);
    add("z16",   0, 0, 0, 0, 1, 0, 0, 0, 5'h00, 0);
    add("run1",  0, 0, 1, 0, 1, 0, 0, 1, 5'h11, 0);
    add("eos",   0, 0, 0, 0, 0, 0, 1, 1, 5'h00, 1);
    add("idle2", 0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0);
    // back-pressure: 7 loads, held 4 cycles while 1 is offered
    add("bp7",   0, 7, 0, 0, 1, 1, 0, 1, 5'h07, 0);
    for (int k = 0; k < 4; k++)
      add("bphold", 0, 1, 0, 0, 1, 1, 1, 1, 5'h07, 0);
    add("bp1",   0, 1, 0, 0, 1, 0, 0, 1, 5'h01, 0);
    add("idle3", 0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0);
    // bypass zero after one zero
    add("bz1",   0, 0, 0, 0, 1, 0, 0, 0, 5'h00, 0);
    add("brun1", 0, 0, 0, 1, 1, 0, 0, 1, 5'h11, 0);
    add("blit0", 0, 0, 0, 0, 0, 0, 1, 1, 5'h00, 0);
    add("idle4", 0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0);
    // partial run discarded by reset
    add("rz1",   0, 0, 0, 0, 1, 0, 0, 0, 5'h00, 0);
    add("rz2",   0, 0, 0, 0, 1, 0, 0, 0, 5'h00, 0);
    add("rz3",   0, 0, 0, 0, 1, 0, 0, 0, 5'h00, 0);
    add("rrst",  1, 0, 0, 0, 0, 0, 1, 0, 5'h00, 0);
    add("reos",  0, 0, 1, 0, 1, 0, 0, 1, 5'h00, 1);
    add("idle5", 0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0);
    // idle does not flush; bypass literal mid-stream after pending drain under o_b
    add("iz1",   0, 0, 0, 0, 1, 0, 0, 0, 5'h00, 0);
    add("iidle", 0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0);
    add("irun",  0, 6, 0, 0, 1, 1, 0, 1, 5'h11, 0);
    add("ipend", 0, 0, 0, 0, 0, 1, 1, 1, 5'h11, 0);
    add("ilit6", 0, 0, 0, 0, 0, 0, 1, 1, 5'h06, 0);
    add("idle6", 0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0);

    foreach (vq[n]) begin
      reset = vq[n].rst; i_d = vq[n].d; i_eos = vq[n].eos; i_byp = vq[n].byp;
      i_v = vq[n].v; o_b = vq[n].ob;
      #1;
      chk({vq[n].nm, ".i_b"}, 32'(i_b), 32'(vq[n].ib));
      @(posedge clock); #1;
      chk({vq[n].nm, ".o_v"}, 32'(o_v), 32'(vq[n].ov));
      if (vq[n].ov || vq[n].rst) begin
        chk({vq[n].nm, ".o_d"}, 32'(o_d), 32'(vq[n].od));
        chk({vq[n].nm, ".o_eos"}, 32'(o_eos), 32'(vq[n].oeos));
      end
    end
    reset = 0; i_v = 0; o_b = 0;

    // wide instance: 12 zeros then 0xA5 -> runs 5,5,2 then literal A5
    for (int k = 1; k <= 12; k++) begin
      d2 = 8'h00; v2 = 1; #1;
      chk("w.i_b", 32'(ib2), 32'd0);
      @(posedge clock); #1;
      chk("w.o_v", 32'(ov2), (k == 5 || k == 10) ? 32'd1 : 32'd0);
      if (k == 5 || k == 10) chk("w.run5", 32'(od2), 32'h105);
    end
    d2 = 8'hA5; v2 = 1; #1;
    chk("w.i_b_a5", 32'(ib2), 32'd0);
    @(posedge clock); #1;
    chk("w.run2.v", 32'(ov2), 32'd1);
    chk("w.run2", 32'(od2), 32'h102);
    v2 = 0; #1;
    chk("w.i_b_pend", 32'(ib2), 32'd1);
    @(posedge clock); #1;
    chk("w.lit.v", 32'(ov2), 32'd1);
    chk("w.lit", 32'(od2), 32'h0A5);
    chk("w.lit.eos", 32'(oeos2), 32'd0);
    @(posedge clock); #1;
    chk("w.drain", 32'(ov2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/zle_param.md
Name: zle_param

Overview:
- Parametrised zero run-length encoder for the token-stream datapath, with valid/back-pressure streams on both sides.
- Nonzero input words pass through as literal tokens. Runs of zero words are collapsed into one run token carrying the run length.
- Adds three things to the fixed 3-bit encoder: configurable data/count widths with a configurable maximum run, an end-of-stream flush with an explicit EOS token, and a per-word bypass mode.

Parameters:
DW  3  input data width
CW  4  run-count width
MAXRUN  15  maximum run length per run token; legal range 1..2^CW-1 (out of range is an elaboration error)
OW  max(DW,CW)+1  output token width (derived localparam, not overridable)

Ports:
clock  in  1  single clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
i_d  in  DW  input data word
i_eos  in  1  end-of-stream marker, qualified by i_v; i_d ignored when set
i_byp  in  1  bypass: zero word emitted as literal, qualified by i_v
i_v  in  1  input valid
i_b  out  1  input busy; transfer when i_v && !i_b
o_d  out  OW  output token: [OW-1]=1 run token, length in [CW-1:0]; [OW-1]=0 literal, data in [DW-1:0]; unused bits 0
o_eos  out  1  output token is EOS (o_d=0)
o_v  out  1  output valid (registered)
o_b  in  1  output busy; transfer when o_v && !o_b

Behaviour:
- Reset, sampled at the clock edge, forces: o_v=0, o_d=0, o_eos=0, cnt=0, state=ACCEPT, pending literal cleared. i_b=1 while reset is high. Reset mid-run or mid-PEND discards the partial count and any pending token with no flush.
- Output register:
  - can_load = !o_v || !o_b.
  - o_d/o_eos are held stable while o_v && o_b.
  - o_v drops after a transfer unless a new token loads in the same cycle, which gives full throughput.
- Latency: an accepted word that produces a token shows it on o_v the next cycle.
- State ACCEPT: i_b = !can_load (combinational). On input transfer, exactly one of the following applies:
  - eos, cnt>0: load run token(cnt), cnt<=0, go PEND_EOS.
  - eos, cnt=0: load EOS token, stay.
  - i_d==0 && !i_byp: cnt<=cnt+1. If cnt+1==MAXRUN, load run token(MAXRUN) and cnt<=0; otherwise no token.
  - i_d!=0 || i_byp, cnt=0: load literal(i_d).
  - i_d!=0 || i_byp, cnt>0: load run token(cnt), cnt<=0, capture i_d into the pending register, go PEND_LIT.
- State PEND_LIT: i_b=1. When can_load, load literal(pending) and go ACCEPT.
- State PEND_EOS: i_b=1. When can_load, load EOS token and go ACCEPT.
- cnt never exceeds MAXRUN-1 while at rest in ACCEPT. A run token always carries a length in 1..MAXRUN. A run of exactly MAXRUN followed by a nonzero word emits the full run token, then the literal; no zero-length run token is emitted.
- After EOS the block returns to ACCEPT with cnt=0 and accepts a new stream immediately.
- Invalid state encodings recover to ACCEPT with cnt=0.
- i_v=0 leaves cnt and state unchanged. Idle periods never flush a partial run; only EOS or a nonzero/bypass word does.
- Input-side transfers and output-side drains may happen in the same cycle.

Test Plan:
- Defaults, o_b=0; inputs 5,0,0,3 -> o_d tokens 0_0101 (literal 5), 1_0010 (run 2), 0_0011 (literal 3); i_b high exactly one cycle after the word 3 is accepted.
- 16 zeros then EOS -> run token 1_1111 (15) issued the cycle after the 15th zero; then run 1_0001; then o_eos=1 with o_d=0.
- o_b held 1 for 4 cycles with 7,1 offered -> o_v=1 and o_d=0_0111 stable all 4 cycles, i_b=1; after o_b drops, literal 7 then 1 on consecutive cycles.
- Inputs 0,0 with i_byp=1 on the second zero -> run 1_0001, then literal 0_0000.
- Inputs 0,0,0 then reset for 1 cycle, then EOS -> only an EOS token is produced; no run token is output.
- DW=8, CW=3, MAXRUN=5: 12 zeros, then 0xA5 -> runs 5, 5, 2, then literal 0_1010_0101 (OW=9).
